// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline.
// Instruction constants, fetch FSM state type and reset PC.
package core_pkg;

  localparam logic [31:0] NOP_INST    = 32'h00000013;
  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: captured pc, pc+4, instruction, valid.
// Flush inserts a NOP bubble and keeps the pc fields.
module ifid_reg
  import core_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [N-1:0] d_pc,
  input  logic [N-1:0] d_pc4,
  input  logic [31:0]  d_inst,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc4,
  output logic [31:0]  inst,
  output logic         valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      pc4   <= '0;
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (flush) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= d_pc;
      pc4   <= d_pc4;
      inst  <= d_inst;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and RUN/HALT FSM.
// Feeds the IF/ID register with stall, redirect-flush and ebreak halt.
module if_stage
  import core_pkg::*;
#(
  parameter int unsigned  N        = 32,
  parameter int unsigned  ADDR_W   = 6,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [N-1:0]      branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [N-1:0]      pc,
  output logic [N-1:0]      ifid_pc,
  output logic [N-1:0]      ifid_pc4,
  output logic [31:0]       ifid_inst,
  output logic              ifid_valid,
  output logic              halted,
  output logic              misaligned
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [N-1:0] pc_next;
  logic [N-1:0] pc_plus4;
  logic         load;
  logic         flush;
  logic         mis_set;

  assign pc_plus4  = pc + N'(4);
  assign imem_addr = pc[ADDR_W+1:2];
  assign halted    = (state == HALT);

  always_comb begin
    pc_next    = pc;
    state_next = state;
    load       = 1'b0;
    flush      = 1'b0;
    mis_set    = 1'b0;
    unique case (state)
      RUN: begin
        if (branch_taken) begin
          pc_next = {branch_target[N-1:2], 2'b00};
          flush   = 1'b1;
          mis_set = |branch_target[1:0];
        end else if (!stall) begin
          load = 1'b1;
          if (imem_data == EBREAK_INST)
            state_next = HALT;
          else
            pc_next = pc_plus4;
        end
      end
      HALT: begin
        // Drop the captured ebreak once; later flushes are no-ops.
        flush = !stall;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= RUN;
      misaligned <= 1'b0;
    end else begin
      pc    <= pc_next;
      state <= state_next;
      if (mis_set)
        misaligned <= 1'b1;
    end
  end

  ifid_reg #(.N(N)) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .flush  (flush),
    .d_pc   (pc),
    .d_pc4  (pc_plus4),
    .d_inst (imem_data),
    .pc     (ifid_pc),
    .pc4    (ifid_pc4),
    .inst   (ifid_inst),
    .valid  (ifid_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, redirect, misalign,
// halt, PC wrap and asynchronous reset.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] EBK = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic        halted;
  logic        misaligned;

  logic [31:0] mem [64];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .ifid_pc       (ifid_pc),
    .ifid_pc4      (ifid_pc4),
    .ifid_inst     (ifid_inst),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .misaligned    (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_ifid_pc"}, ifid_pc, 32'h0);
    chk({tag, "_ifid_pc4"}, ifid_pc4, 32'h0);
    chk({tag, "_inst"}, ifid_inst, NOP);
    chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'h0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
    chk({tag, "_mis"}, {31'b0, misaligned}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      mem[i] = 32'h00000093 | (i << 20);
    mem[0]  = 32'h00002083;
    mem[1]  = 32'h00402103;
    mem[2]  = 32'h00802183;
    mem[3]  = 32'h0020e233;
    mem[5]  = EBK;
    mem[63] = 32'hcafe0113;

    // reset
    step();
    step();
    chk_reset("rst");
    chk("rst_addr", {26'b0, imem_addr}, 32'h0);
    rst = 1'b0;

    // sequential fetch
    step();
    chk("f1_pc", pc, 32'd4);
    chk("f1_ifid_pc", ifid_pc, 32'd0);
    chk("f1_pc4", ifid_pc4, 32'd4);
    chk("f1_inst", ifid_inst, 32'h00002083);
    chk("f1_valid", {31'b0, ifid_valid}, 32'h1);
    step();
    chk("f2_pc", pc, 32'd8);
    chk("f2_ifid_pc", ifid_pc, 32'd4);
    chk("f2_inst", ifid_inst, 32'h00402103);
    chk("f2_addr", {26'b0, imem_addr}, 32'd2);

    // stall two cycles at pc=8
    stall = 1'b1;
    step();
    chk("s1_pc", pc, 32'd8);
    chk("s1_ifid_pc", ifid_pc, 32'd4);
    chk("s1_inst", ifid_inst, 32'h00402103);
    step();
    chk("s2_pc", pc, 32'd8);
    chk("s2_ifid_pc", ifid_pc, 32'd4);
    chk("s2_valid", {31'b0, ifid_valid}, 32'h1);
    stall = 1'b0;
    step();
    chk("f3_pc", pc, 32'd12);
    chk("f3_ifid_pc", ifid_pc, 32'd8);
    chk("f3_inst", ifid_inst, 32'h00802183);
    step();
    chk("f4_pc", pc, 32'd16);
    chk("f4_ifid_pc", ifid_pc, 32'd12);
    chk("f4_inst", ifid_inst, 32'h0020e233);

    // branch with simultaneous stall
    branch_taken  = 1'b1;
    branch_target = 32'd24;
    stall         = 1'b1;
    step();
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("b1_pc", pc, 32'd24);
    chk("b1_valid", {31'b0, ifid_valid}, 32'h0);
    chk("b1_inst", ifid_inst, NOP);
    chk("b1_ifid_pc", ifid_pc, 32'd12);
    step();
    chk("b2_ifid_pc", ifid_pc, 32'd24);
    chk("b2_valid", {31'b0, ifid_valid}, 32'h1);
    chk("b2_inst", ifid_inst, 32'h00600093);
    chk("b2_pc", pc, 32'd28);

    // misaligned redirect
    branch_taken  = 1'b1;
    branch_target = 32'h1E;
    step();
    branch_taken = 1'b0;
    chk("m_pc", pc, 32'h1C);
    chk("m_mis", {31'b0, misaligned}, 32'h1);
    chk("m_valid", {31'b0, ifid_valid}, 32'h0);
    for (int i = 0; i < 10; i++)
      step();
    chk("m10_mis", {31'b0, misaligned}, 32'h1);
    chk("m10_pc", pc, 32'h44);
    chk("m10_ifid_pc", ifid_pc, 32'h40);
    chk("m10_inst", ifid_inst, 32'h01000093);

    // halt on ebreak at word 5
    branch_taken  = 1'b1;
    branch_target = 32'd20;
    step();
    branch_taken = 1'b0;
    chk("h0_pc", pc, 32'd20);
    chk("h0_halted", {31'b0, halted}, 32'h0);
    step();
    chk("h1_inst", ifid_inst, EBK);
    chk("h1_valid", {31'b0, ifid_valid}, 32'h1);
    chk("h1_ifid_pc", ifid_pc, 32'd20);
    chk("h1_pc", pc, 32'd20);
    chk("h1_halted", {31'b0, halted}, 32'h1);
    branch_taken  = 1'b1;
    branch_target = 32'd0;
    step();
    chk("h2_inst", ifid_inst, NOP);
    chk("h2_valid", {31'b0, ifid_valid}, 32'h0);
    chk("h2_pc", pc, 32'd20);
    chk("h2_halted", {31'b0, halted}, 32'h1);
    step();
    branch_taken = 1'b0;
    chk("h3_pc", pc, 32'd20);
    chk("h3_valid", {31'b0, ifid_valid}, 32'h0);

    // leave halt via reset
    rst = 1'b1;
    #1;
    chk_reset("r2");
    step();
    rst = 1'b0;

    // wrap: misaligned redirect to the last word
    branch_taken  = 1'b1;
    branch_target = 32'hFFFFFFFF;
    step();
    branch_taken = 1'b0;
    chk("w0_pc", pc, 32'hFFFFFFFC);
    chk("w0_addr", {26'b0, imem_addr}, 32'h3F);
    chk("w0_mis", {31'b0, misaligned}, 32'h1);
    step();
    chk("w1_pc", pc, 32'h0);
    chk("w1_ifid_pc", ifid_pc, 32'hFFFFFFFC);
    chk("w1_pc4", ifid_pc4, 32'h0);
    chk("w1_inst", ifid_inst, 32'hcafe0113);
    chk("w1_valid", {31'b0, ifid_valid}, 32'h1);
    step();
    chk("w2_pc", pc, 32'h4);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk_reset("ar");
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV32I core. Holds the program counter, drives the word address into the 64-entry instruction memory, and captures the fetched word into the IF/ID pipeline register consumed by decode and register-file read. Supports stall, branch/jump redirect with flush, and halt on `ebreak`.

## Interface

- `N`, 32, PC and datapath width.
- `ADDR_W`, 6, instruction-memory word-address width (64 words).
- `RESET_PC`, 0, byte address loaded into the PC on reset.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the PC and the IF/ID register this cycle.
- `branch_taken`  in  1  redirect the PC to `branch_target` and flush IF/ID.
- `branch_target`  in  N  redirect byte address.
- `imem_addr`  out  ADDR_W  `pc[ADDR_W+1:2]`, combinational.
- `imem_data`  in  32  instruction word returned combinationally by instruction memory.
- `pc`  out  N  current PC.
- `ifid_pc`  out  N  PC of the captured instruction.
- `ifid_pc4`  out  N  `ifid_pc + 4`.
- `ifid_inst`  out  32  captured instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  FSM is in HALT.
- `misaligned`  out  1  sticky: a redirect target had `[1:0] != 0`.

## Operation

- FSM states are RUN and HALT. Reset enters RUN.
- **Reset values:**
  - `pc` = RESET_PC.
  - `ifid_pc` = 0, `ifid_pc4` = 0.
  - `ifid_inst` = NOP (32'h00000013).
  - `ifid_valid` = 0, `halted` = 0, `misaligned` = 0.
- **RUN, per-cycle priority (highest first):**
  1. `branch_taken`: `pc <= {branch_target[N-1:2], 2'b00}`. IF/ID is flushed (`ifid_inst <= NOP`, `ifid_valid <= 0`, `ifid_pc` and `ifid_pc4` unchanged). If `branch_target[1:0] != 0`, set `misaligned`.
  2. `stall`: the PC and all IF/ID fields hold.
  3. Otherwise:
     - `ifid_pc <= pc`, `ifid_pc4 <= pc + 4`, `ifid_inst <= imem_data`, `ifid_valid <= 1`.
     - `pc <= pc + 4`.
     - If `imem_data` == EBREAK (32'h00100073), go to HALT. The `ebreak` itself is still captured with valid = 1. The PC does not advance: it stays at the `ebreak` address.
- **HALT:**
  - The PC is frozen and `halted = 1`.
  - On the first HALT edge not blocked by `stall`: `ifid_inst <= NOP`, `ifid_valid <= 0`. IF/ID then holds.
  - `branch_taken` and `stall` are ignored.
  - HALT is left only by `rst`.
- **Arithmetic:** `pc + 4` is modulo 2^N. 32'hFFFFFFFC + 4 = 0.
- **Address wrap:** `imem_addr` takes the low ADDR_W word bits only, so byte address 256 maps to word 0.
- `misaligned` clears only on `rst`.
- Reset asserted mid-operation takes effect immediately and asynchronously: all outputs go to their reset values without a clock edge.

## Timing

- Fetch latency is one cycle. The instruction at PC p appears on `ifid_inst` the cycle after the edge at which p was current and neither stalled nor redirected.
- `imem_addr` follows `pc` combinationally with zero cycles of latency.
- **Redirect:**
  - Sampled at the edge where `branch_taken` = 1.
  - The next cycle shows `pc` = target and `ifid_valid` = 0.
  - The cycle after that, `ifid_valid` = 1 with the target instruction.
  - Penalty is one bubble.
- `stall` and `branch_taken` asserted in the same cycle: the redirect wins.
- Back-to-back redirects are each taken. Every one flushes.
- The `stall` input must be stable before the rising edge. There is no combinational path from `stall` or `branch_taken` to any output.

## Structure

- **Shared package** `core_pkg`:
  - `NOP_INST` = 32'h00000013.
  - `EBREAK_INST` = 32'h00100073.
  - Fetch FSM state type with values RUN and HALT.
  - `RESET_PC` default.
- **Sub-module** `ifid_reg`:
  - Holds the IF/ID pipeline register: `pc`, `pc4`, `inst`, `valid`.
  - Inputs are `load` and `flush`. Flush forces NOP and valid = 0.
  - Uses the same asynchronous reset.
- The PC register, next-PC mux and FSM live in `if_stage`.

## Test plan

- **Reset and sequential fetch:**
  - Stimulus: memory words 0..3 = lw/lw/lw/or, `rst` pulse, then 4 free-running cycles.
  - Required: `pc` steps 0, 4, 8, 12, 16. `ifid_pc` steps 0, 4, 8, 12. `ifid_inst` matches the words. `ifid_valid` = 1 from the first post-reset edge.
- **Stall:**
  - Stimulus: `stall` = 1 for 2 cycles at `pc` = 8.
  - Required: `pc` and `ifid_*` frozen for 2 cycles, then fetch resumes at 8.
- **Branch with simultaneous stall:**
  - Stimulus: at `pc` = 16, `branch_taken` = 1, `branch_target` = 24, `stall` = 1.
  - Required: next cycle `pc` = 24 and `ifid_valid` = 0. Following cycle `ifid_pc` = 24 and valid = 1.
- **Misaligned target:**
  - Stimulus: `branch_target` = 0x1E.
  - Required: `pc` = 0x1C and `misaligned` = 1. After a further 10 cycles, `misaligned` is still 1.
- **Halt:**
  - Stimulus: word 5 = EBREAK.
  - Required: `ifid_inst` = 0x00100073 with valid = 1, then NOP with valid = 0. `pc` = 20 and `halted` = 1, with `pc` held despite `branch_taken` = 1.
- **Wrap and asynchronous reset:**
  - Stimulus: redirect to 0xFFFFFFFC and fetch one instruction; then assert `rst` between clock edges.
  - Required: after the fetch, `pc` = 0 and `imem_addr` = 6'h3F was used for the fetch. On `rst`, all outputs take their reset values before the next edge.
